axi_initiator: RTL and testbench

AXI3-style master that drives the MaxiO channel bundle (AR, AW, W) and consumes the MaxiI bundle (R, B). It converts single-beat user read and write burst requests into address/data/response channel traffic and returns read beats and write completions to the user side. It is the initiator-side counterpart of the existing AXI slave/portal logic and is used to drive that logic from a bench or from on-chip masters. Reads and writes are independent and may be in flight concurrently, with one burst outstanding per direction.

---
 rtl/axi_pkg.sv | 14 +
 rtl/axi_burst_counter.sv | 23 ++
 rtl/axi_initiator.sv | 172 +++++++++++++++++
 tb/tb_axi_initiator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI initiator: FSM state encodings,
// response codes and burst-length widths.
package axi_pkg;
  localparam int LEN_W = 4;
  localparam int CNT_W = LEN_W + 1;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} ReadState;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} WriteState;
endpackage

// File: rtl/axi_burst_counter.sv
// Beat counter for one burst direction: cleared on load, bumped per beat,
// flags the final beat of a len+1 beat burst.
module axi_burst_counter
  import axi_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             last_o
);
  logic [CNT_W-1:0] count_q;

  // One extra bit over len so a 16-beat burst never wraps back to zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       count_q <= '0;
    else if (load_i) count_q <= '0;
    else if (inc_i)  count_q <= count_q + 1'b1;
  end

  assign last_o = (count_q == CNT_W'(len_i));
endmodule

// File: rtl/axi_initiator.sv
// AXI3-style initiator: independent read and write FSMs turning single-beat
// user burst requests into AR/AW/W traffic and R/B responses.
module axi_initiator
  import axi_pkg::*;
#(
  parameter logic [11:0] ID = 12'd0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             readReq__ENA,
  input  logic [31:0]      readReq_addr,
  input  logic [LEN_W-1:0] readReq_len,
  output logic             readReq__RDY,
  output logic             readData__ENA,
  output logic [31:0]      readData_data,
  output logic             readData_last,
  input  logic             readData__RDY,
  input  logic             writeReq__ENA,
  input  logic [31:0]      writeReq_addr,
  input  logic [LEN_W-1:0] writeReq_len,
  output logic             writeReq__RDY,
  input  logic             writeData__ENA,
  input  logic [31:0]      writeData_data,
  output logic             writeData__RDY,
  output logic             writeDone__ENA,
  output logic [1:0]       writeDone_resp,
  input  logic             writeDone__RDY,
  output logic             AR__ENA,
  output logic [31:0]      AR_addr,
  output logic [11:0]      AR_id,
  output logic [LEN_W-1:0] AR_len,
  input  logic             AR__RDY,
  output logic             AW__ENA,
  output logic [31:0]      AW_addr,
  output logic [11:0]      AW_id,
  output logic [LEN_W-1:0] AW_len,
  input  logic             AW__RDY,
  output logic             W__ENA,
  output logic [31:0]      W_data,
  output logic [11:0]      W_id,
  output logic             W_last,
  input  logic             W__RDY,
  input  logic             R__ENA,
  input  logic [31:0]      R_data,
  input  logic [11:0]      R_id,
  input  logic             R_last,
  input  logic [1:0]       R_resp,
  output logic             R__RDY,
  input  logic             B__ENA,
  input  logic [11:0]      B_id,
  input  logic [1:0]       B_resp,
  output logic             B__RDY,
  output logic             rdError,
  output logic             wrError
);
  ReadState         rd_state_q, rd_state_d;
  logic [31:0]      rd_addr_q;
  logic [LEN_W-1:0] rd_len_q;
  logic             rd_err_q, rd_err_d, rd_last;
  logic             rd_req_fire, r_fire;

  WriteState        wr_state_q, wr_state_d;
  logic [31:0]      wr_addr_q;
  logic [LEN_W-1:0] wr_len_q;
  logic             wr_err_q, wr_err_d, wr_last;
  logic             wr_req_fire, w_fire, b_fire;

  assign rd_req_fire = readReq__ENA && (rd_state_q == R_IDLE);
  assign r_fire      = R__ENA && readData__RDY && (rd_state_q == R_DATA);
  assign wr_req_fire = writeReq__ENA && (wr_state_q == W_IDLE);
  assign w_fire      = writeData__ENA && W__RDY && (wr_state_q == W_DATA);
  assign b_fire      = B__ENA && writeDone__RDY && (wr_state_q == W_RESP);

  axi_burst_counter u_rd_cnt (
    .CLK(CLK), .nRST(nRST), .load_i(rd_req_fire), .inc_i(r_fire),
    .len_i(rd_len_q), .last_o(rd_last)
  );

  axi_burst_counter u_wr_cnt (
    .CLK(CLK), .nRST(nRST), .load_i(wr_req_fire), .inc_i(w_fire),
    .len_i(wr_len_q), .last_o(wr_last)
  );

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_err_d      = rd_err_q;
    readReq__RDY  = (rd_state_q == R_IDLE);
    AR__ENA       = (rd_state_q == R_ADDR);
    AR_addr       = rd_addr_q;
    AR_id         = ID;
    AR_len        = rd_len_q;
    R__RDY        = (rd_state_q == R_DATA) && readData__RDY;
    readData__ENA = (rd_state_q == R_DATA) && R__ENA;
    readData_data = R_data;
    readData_last = rd_last;
    unique case (rd_state_q)
      R_IDLE: if (readReq__ENA) rd_state_d = R_ADDR;
      R_ADDR: if (AR__RDY)      rd_state_d = R_DATA;
      // An early R_last from the slave still terminates the burst.
      R_DATA: if (r_fire && (rd_last || R_last)) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
    if (r_fire && (R_resp != OKAY || R_id != ID || R_last != rd_last))
      rd_err_d = 1'b1;
    if (R__ENA && rd_state_q != R_DATA)
      rd_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_err_q   <= rd_err_d;
      if (rd_req_fire) begin
        rd_addr_q <= readReq_addr;
        rd_len_q  <= readReq_len;
      end
    end
  end

  always_comb begin
    wr_state_d     = wr_state_q;
    wr_err_d       = wr_err_q;
    writeReq__RDY  = (wr_state_q == W_IDLE);
    AW__ENA        = (wr_state_q == W_ADDR);
    AW_addr        = wr_addr_q;
    AW_id          = ID;
    AW_len         = wr_len_q;
    W__ENA         = (wr_state_q == W_DATA) && writeData__ENA;
    W_data         = writeData_data;
    W_id           = ID;
    W_last         = wr_last;
    writeData__RDY = (wr_state_q == W_DATA) && W__RDY;
    B__RDY         = (wr_state_q == W_RESP) && writeDone__RDY;
    writeDone__ENA = (wr_state_q == W_RESP) && B__ENA;
    writeDone_resp = B_resp;
    unique case (wr_state_q)
      W_IDLE: if (writeReq__ENA)       wr_state_d = W_ADDR;
      W_ADDR: if (AW__RDY)             wr_state_d = W_DATA;
      W_DATA: if (w_fire && wr_last)   wr_state_d = W_RESP;
      W_RESP: if (b_fire)              wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
    if (b_fire && (B_resp != OKAY || B_id != ID))
      wr_err_d = 1'b1;
    if (B__ENA && wr_state_q != W_RESP)
      wr_err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_err_q   <= wr_err_d;
      if (wr_req_fire) begin
        wr_addr_q <= writeReq_addr;
        wr_len_q  <= writeReq_len;
      end
    end
  end

  assign rdError = rd_err_q;
  assign wrError = wr_err_q;
endmodule

// File: tb/tb_axi_initiator.sv
// Scoreboard bench for axi_initiator: directed stimulus pushes expected
// channel beats; a negedge monitor pops and compares on every fire.
module tb_axi_initiator;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        rq_ena = 0, rq_rdy;  logic [31:0] rq_addr = 0; logic [3:0] rq_len = 0;
  logic        rd_ena, rd_last, rd_rdy = 1; logic [31:0] rd_data;
  logic        wq_ena = 0, wq_rdy;  logic [31:0] wq_addr = 0; logic [3:0] wq_len = 0;
  logic        wd_ena = 0, wd_rdy;  logic [31:0] wd_data = 0;
  logic        dn_ena, dn_rdy = 1;  logic [1:0] dn_resp;
  logic        ar_ena, ar_rdy = 1;  logic [31:0] ar_addr; logic [11:0] ar_id; logic [3:0] ar_len;
  logic        aw_ena, aw_rdy = 1;  logic [31:0] aw_addr; logic [11:0] aw_id; logic [3:0] aw_len;
  logic        w_ena, w_rdy = 1, w_last; logic [31:0] w_data; logic [11:0] w_id;
  logic        r_ena = 0, r_last = 0, r_rdy; logic [31:0] r_data = 0;
  logic [11:0] r_id = 0; logic [1:0] r_resp = 0;
  logic        b_ena = 0, b_rdy; logic [11:0] b_id = 0; logic [1:0] b_resp = 0;
  logic        rdError, wrError;

  int n_chk = 0, n_fail = 0;
  logic [35:0] exp_ar[$], exp_aw[$];
  logic [32:0] exp_rd[$], exp_w[$];
  logic [1:0]  exp_dn[$];

  always #5 CLK = ~CLK;

  axi_initiator #(.ID(12'd0)) dut (
    .CLK(CLK), .nRST(nRST),
    .readReq__ENA(rq_ena), .readReq_addr(rq_addr), .readReq_len(rq_len), .readReq__RDY(rq_rdy),
    .readData__ENA(rd_ena), .readData_data(rd_data), .readData_last(rd_last), .readData__RDY(rd_rdy),
    .writeReq__ENA(wq_ena), .writeReq_addr(wq_addr), .writeReq_len(wq_len), .writeReq__RDY(wq_rdy),
    .writeData__ENA(wd_ena), .writeData_data(wd_data), .writeData__RDY(wd_rdy),
    .writeDone__ENA(dn_ena), .writeDone_resp(dn_resp), .writeDone__RDY(dn_rdy),
    .AR__ENA(ar_ena), .AR_addr(ar_addr), .AR_id(ar_id), .AR_len(ar_len), .AR__RDY(ar_rdy),
    .AW__ENA(aw_ena), .AW_addr(aw_addr), .AW_id(aw_id), .AW_len(aw_len), .AW__RDY(aw_rdy),
    .W__ENA(w_ena), .W_data(w_data), .W_id(w_id), .W_last(w_last), .W__RDY(w_rdy),
    .R__ENA(r_ena), .R_data(r_data), .R_id(r_id), .R_last(r_last), .R_resp(r_resp), .R__RDY(r_rdy),
    .B__ENA(b_ena), .B_id(b_id), .B_resp(b_resp), .B__RDY(b_rdy),
    .rdError(rdError), .wrError(wrError)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s actual=fire expected=no-fire", nm);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (nRST) begin
      if (ar_ena && ar_rdy) begin
        if (exp_ar.size() == 0) unexpected("ar_unexp");
        else begin check("ar", {ar_addr, ar_len}, exp_ar.pop_front()); check("ar_id", ar_id, 0); end
      end
      if (aw_ena && aw_rdy) begin
        if (exp_aw.size() == 0) unexpected("aw_unexp");
        else begin check("aw", {aw_addr, aw_len}, exp_aw.pop_front()); check("aw_id", aw_id, 0); end
      end
      if (w_ena && w_rdy) begin
        if (exp_w.size() == 0) unexpected("w_unexp");
        else begin check("w", {w_data, w_last}, exp_w.pop_front()); check("w_id", w_id, 0); end
      end
      if (rd_ena && rd_rdy) begin
        if (exp_rd.size() == 0) unexpected("rd_unexp");
        else check("rdata", {rd_data, rd_last}, exp_rd.pop_front());
      end
      if (dn_ena && dn_rdy) begin
        if (exp_dn.size() == 0) unexpected("done_unexp");
        else check("done_resp", dn_resp, exp_dn.pop_front());
      end
    end
  end

  function automatic logic fired(input int ch);
    case (ch)
      0:       return ar_ena && ar_rdy;
      1:       return aw_ena && aw_rdy;
      2:       return w_ena && w_rdy;
      3:       return r_ena && r_rdy;
      default: return b_ena && b_rdy;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Waits for a handshake on channel ch, returning #1 after the firing edge.
  task automatic wait_fire(input int ch, input string nm);
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (fired(ch)) begin step(); return; end
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic send_r(input logic [31:0] d, input logic lst, input logic exp_last);
    exp_rd.push_back({d, exp_last});
    r_ena = 1; r_data = d; r_last = lst;
    wait_fire(3, "r");
    r_ena = 0; r_last = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic exp_last);
    exp_w.push_back({d, exp_last});
    wd_ena = 1; wd_data = d;
    wait_fire(2, "w");
    wd_ena = 0;
  endtask

  task automatic send_b(input logic [1:0] rsp);
    exp_dn.push_back(rsp);
    b_ena = 1; b_resp = rsp;
    wait_fire(4, "b");
    b_ena = 0; b_resp = 0;
  endtask

  task automatic read_req(input logic [31:0] a, input logic [3:0] l);
    exp_ar.push_back({a, l});
    rq_ena = 1; rq_addr = a; rq_len = l;
    step();
    rq_ena = 0;
  endtask

  task automatic write_req(input logic [31:0] a, input logic [3:0] l);
    exp_aw.push_back({a, l});
    wq_ena = 1; wq_addr = a; wq_len = l;
    step();
    wq_ena = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_readReq_rdy"}, rq_rdy, 1);
    check({tag, "_writeReq_rdy"}, wq_rdy, 1);
    check({tag, "_enas"}, {ar_ena, aw_ena, w_ena, rd_ena, dn_ena}, 0);
    check({tag, "_rdys"}, {r_rdy, b_rdy, wd_rdy}, 0);
    check({tag, "_errs"}, {rdError, wrError}, 0);
  endtask

  initial begin
    #3 check_idle("reset");
    #9 nRST = 1;
    step();

    // Read len=3, four beats, last only on the fourth
    rq_ena = 1; rq_addr = 32'h1000; rq_len = 4'd3; exp_ar.push_back({32'h1000, 4'd3});
    step(); rq_ena = 0;
    check("ar_next_cycle", ar_ena, 1);
    wait_fire(0, "ar");
    send_r(32'hA0, 0, 0); send_r(32'hA1, 0, 0);
    send_r(32'hA2, 0, 0); send_r(32'hA3, 1, 1);
    check("t1_idle", rq_rdy, 1);
    check("t1_rdError", rdError, 0);

    // Write len=0 with AW stalled three cycles
    aw_rdy = 0;
    write_req(32'h2000, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("aw_held", {aw_ena, aw_addr, aw_len}, {1'b1, 32'h2000, 4'd0});
      step();
    end
    aw_rdy = 1;
    wait_fire(1, "aw");
    send_w(32'h55, 1);
    send_b(2'd0);
    check("t2_wrError", wrError, 0);
    check("t2_idle", wq_rdy, 1);

    // Concurrent read and write issued in the same cycle
    exp_ar.push_back({32'h3000, 4'd1}); exp_aw.push_back({32'h4000, 4'd1});
    rq_ena = 1; rq_addr = 32'h3000; rq_len = 4'd1;
    wq_ena = 1; wq_addr = 32'h4000; wq_len = 4'd1;
    step(); rq_ena = 0; wq_ena = 0;
    check("ar_aw_same", {ar_ena, aw_ena}, 2'b11);
    fork
      begin wait_fire(0, "ar3"); send_r(32'hB0, 0, 0); send_r(32'hB1, 1, 1); end
      begin wait_fire(1, "aw3"); send_w(32'hC0, 0); send_w(32'hC1, 1); send_b(2'd0); end
    join
    check("t3_idle", {rq_rdy, wq_rdy}, 2'b11);
    check("t3_errs", {rdError, wrError}, 0);

    // Premature R_last on beat 1 of a 4-beat read; SLVERR on B
    read_req(32'h5000, 4'd3);
    wait_fire(0, "ar4");
    send_r(32'hD0, 0, 0);
    send_r(32'hD1, 1, 0);
    check("early_last_idle", rq_rdy, 1);
    check("early_last_rdError", rdError, 1);
    write_req(32'h7000, 4'd0);
    wait_fire(1, "aw4");
    send_w(32'h77, 1);
    send_b(2'd2);
    check("slverr_wrError", wrError, 1);

    // readData__RDY stall mid-burst, then reset during R_DATA
    read_req(32'h6000, 4'd3);
    wait_fire(0, "ar5");
    send_r(32'hE0, 0, 0);
    rd_rdy = 0;
    exp_rd.push_back({32'hE1, 1'b0});
    r_ena = 1; r_data = 32'hE1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_R_rdy", r_rdy, 0);
      check("stall_rd_ena", rd_ena, 1);
      step();
    end
    rd_rdy = 1;
    wait_fire(3, "r_stall");
    r_ena = 0;
    send_r(32'hE2, 0, 0);
    r_ena = 1; r_data = 32'hE3; r_last = 1;
    #2 nRST = 0;
    #1 check_idle("midburst_rst");
    r_ena = 0; r_last = 0;
    #2 nRST = 1;
    step();
    check("post_rst_idle", {rq_rdy, wq_rdy}, 2'b11);
    check("sb_drained", exp_ar.size() + exp_aw.size() + exp_rd.size() + exp_w.size() + exp_dn.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
